// File: rtl/tpu_pkg.sv
// Shared types and defaults for the systolic array front-end blocks.
package tpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int N_DEF          = 4;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/skew_lane.sv
// One skew lane: DEPTH-stage data+tag shift register with advance enable and sync clear.
module skew_lane #(
  parameter int DEPTH      = 1,
  parameter int Data_Width = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  adv,
  input  logic [Data_Width-1:0] in_data,
  input  logic                  in_tag,
  output logic [Data_Width-1:0] out_data,
  output logic                  out_tag
);

  logic [Data_Width-1:0] data_q [DEPTH];
  logic [Data_Width-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]      tag_q;
  logic [DEPTH-1:0]      tag_d;

  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    if (adv) begin
      data_d[0] = in_data;
      tag_d[0]  = in_tag;
      for (int k = 1; k < DEPTH; k++) begin
        data_d[k] = data_q[k-1];
        tag_d[k]  = tag_q[k-1];
      end
    end else begin
      data_d = data_q;
      tag_d  = tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      data_q <= '{default: '0};
      tag_q  <= '0;
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  assign out_data = data_q[DEPTH-1];
  assign out_tag  = tag_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Feeds one edge of the systolic MAC array: lane i delayed by i advances,
// zero flush after the last vector, accumulator clear before each job.
module systolic_skew_feeder
  import tpu_pkg::*;
#(
  parameter int Data_Width = DATA_WIDTH_DEF,
  parameter int N          = N_DEF,
  parameter int LEN_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic [N*Data_Width-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    waitrequest,
  output logic [N*Data_Width-1:0] out_data,
  output logic [N-1:0]            out_valid,
  output logic                    acc_clear,
  output logic                    busy,
  output logic                    done
);

  localparam int DR_W = $clog2(N + 1);

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [DR_W-1:0]         drain_q, drain_d;
  logic                    adv;
  logic [N*Data_Width-1:0] feed_data;
  logic                    feed_tag;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    adv       = 1'b0;
    feed_data = '0;
    feed_tag  = 1'b0;
    in_ready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          cnt_d   = len;
        end else begin
          state_d = S_IDLE;
        end
      end
      // CLEAR ignores waitrequest so the MAC clear is always a single cycle
      S_CLEAR: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             state_d = S_FEED;
      end
      S_FEED: begin
        in_ready = !waitrequest;
        adv      = !waitrequest;
        if (adv && in_valid) begin
          feed_data = in_data;
          feed_tag  = 1'b1;
          cnt_d     = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            if (N == 1) begin
              state_d = S_DONE;
            end else begin
              state_d = S_DRAIN;
              drain_d = DR_W'(N - 1);
            end
          end else begin
            state_d = S_FEED;
          end
        end else begin
          state_d = S_FEED;
        end
      end
      S_DRAIN: begin
        adv = !waitrequest;
        if (adv) begin
          drain_d = drain_q - DR_W'(1);
          if (drain_q == DR_W'(1)) state_d = S_DONE;
          else                     state_d = S_DRAIN;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        adv = !waitrequest;
        if (adv) state_d = S_IDLE;
        else     state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  assign acc_clear = (state_q == S_CLEAR);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_lane #(
      .DEPTH      (i + 1),
      .Data_Width (Data_Width)
    ) u_lane (
      .clk      (clk),
      .clr      (rst),
      .adv      (adv),
      .in_data  (feed_data[lane_lsb(i, Data_Width) +: Data_Width]),
      .in_tag   (feed_tag),
      .out_data (out_data[lane_lsb(i, Data_Width) +: Data_Width]),
      .out_tag  (out_valid[i])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: table of jobs, per-lane scoreboard queues.
module tb_systolic_skew_feeder;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst, start, in_valid, waitrequest;
  logic [LW-1:0]   len;
  logic [N*DW-1:0] in_data, out_data;
  logic [N-1:0]    out_valid;
  logic            in_ready, acc_clear, busy, done;

  systolic_skew_feeder #(.Data_Width(DW), .N(N), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .waitrequest(waitrequest),
    .out_data(out_data), .out_valid(out_valid), .acc_clear(acc_clear),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          t;
  } ent_t;

  typedef struct {
    int          k;
    logic [31:0] vm;       // bit c: in_valid during cycle c after start
    logic [31:0] wm;       // bit c: waitrequest during cycle c
    int          stp;      // cycle with a stray start pulse (0 = none)
    int          rst_at;   // cycle with rst asserted (0 = none)
    int          exp_done; // first cycle done is high (0 = never)
  } job_t;

  int   checks   = 0;
  int   failures = 0;
  ent_t lq [N][$];
  logic [N*DW-1:0] exp_d;
  logic [N-1:0]    exp_t;
  job_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_out_valid"}, {28'd0, out_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_acc_clear"}, {31'd0, acc_clear}, 32'd0);
  endtask

  task automatic run_job(input job_t j);
    int   ph, acc, dr, done_seen, dut_acc;
    logic w, v, rn, adv_m, acc_in;
    ent_t e;
    for (int i = 0; i < N; i++) begin
      lq[i].delete();
      for (int z = 0; z < i; z++) lq[i].push_back('0);
    end
    exp_d = '0;
    exp_t = '0;
    @(negedge clk);
    start = 1'b1; len = LW'(j.k); in_valid = 1'b0; waitrequest = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    ph = 1; acc = 0; dr = 0; done_seen = 0; dut_acc = 0;
    for (int c = 1; c < 32 && ph != 0; c++) begin
      @(negedge clk);
      w = j.wm[c];
      v = j.vm[c];
      rn = (c == j.rst_at);
      waitrequest = w;
      in_valid    = v;
      rst         = rn;
      start       = (c == j.stp);
      len         = 8'd7;
      if (v) begin
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'(acc * 16 + i);
      end else begin
        in_data = $urandom;
      end
      #1;
      check("acc_clear", {31'd0, acc_clear}, {31'd0, ph == 1});
      check("busy", {31'd0, busy}, 32'd1);
      check("done", {31'd0, done}, {31'd0, ph == 4});
      check("in_ready", {31'd0, in_ready}, {31'd0, (ph == 2) && !w});
      check("out_data", out_data, exp_d);
      check("out_valid", {28'd0, out_valid}, {28'd0, exp_t});
      if (in_valid && in_ready) dut_acc++;
      if (ph == 4 && done_seen == 0) done_seen = c;
      @(posedge clk);
      adv_m  = 1'b0;
      acc_in = 1'b0;
      if (rn) begin
        ph = 0;
        exp_d = '0;
        exp_t = '0;
      end else begin
        case (ph)
          1: ph = (j.k == 0) ? 4 : 2;
          2: if (!w) begin adv_m = 1'b1; acc_in = v; end
          3: if (!w) begin adv_m = 1'b1; dr++; if (dr == N - 1) ph = 4; end
          4: if (!w) begin adv_m = 1'b1; ph = 0; end
          default: ph = 0;
        endcase
        if (adv_m) begin
          for (int i = 0; i < N; i++) begin
            e.d = acc_in ? DW'(acc * 16 + i) : '0;
            e.t = acc_in;
            lq[i].push_back(e);
            e = lq[i].pop_front();
            exp_d[i*DW +: DW] = e.d;
            exp_t[i] = e.t;
          end
        end
        if (acc_in) begin
          acc++;
          if (acc == j.k) ph = 3;
        end
      end
    end
    check("done_cycle", done_seen, j.exp_done);
    check("accept_count", dut_acc, acc);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; waitrequest = 1'b0;
    #1 check_idle("post");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0; waitrequest = 1'b0;
    //               k  vm             wm            stp rst done
    tbl[0] = '{3, 32'hFFFF_FFFF, 32'h0,        0,  0,  8};  // basic skew
    tbl[1] = '{2, 32'hFFFF_FFFF, 32'h38,       0,  0,  10}; // 3-cycle stall mid-FEED
    tbl[2] = '{2, ~32'h8,        32'h2,        0,  0,  8};  // bubble, stall during CLEAR
    tbl[3] = '{0, 32'hFFFF_FFFF, 32'h0,        0,  0,  2};  // zero length
    tbl[4] = '{3, 32'hFFFF_FFFF, 32'h0,        3,  0,  8};  // stray start in FEED
    tbl[5] = '{3, 32'hFFFF_FFFF, 32'h0,        0,  6,  0};  // reset in DRAIN
    tbl[6] = '{4, ~32'h8,        32'h100,      0,  0,  11}; // bubble + DRAIN stall
    tbl[7] = '{1, 32'hFFFF_FFFF, 32'h40,       0,  0,  6};  // stall while DONE
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check_idle("reset");
    rst = 1'b0;
    for (int t = 0; t < 8; t++) run_job(tbl[t]);
    // start coincident with rst must be ignored
    @(negedge clk);
    rst = 1'b1; start = 1'b1; len = 8'd2;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1 check_idle("rst_start");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream feeder for the N×N systolic MAC array. It accepts one N-lane operand vector per cycle from the operand buffer and staggers lane i by i cycles so that operands enter the array edge on a diagonal wavefront. It also flushes the skew with zeros after the last vector, pulses an accumulator clear before each job, and applies `waitrequest` stalls in lockstep with the MAC cells. One instance drives the left edge (`inLeft` of row i) and a second drives the top edge (`inTop` of column i).

## Interface
- `Data_Width`, 8: operand width, signed two's complement.
- `N`, 4: array dimension and lane count.
- `LEN_W`, 8: width of the job-length field.

- `clk`  in  1  : single clock, posedge.
- `rst`  in  1  : synchronous, active-high reset.
- `start`  in  1  : begin a job; sampled in IDLE only.
- `len`  in  LEN_W  : number of vectors K in the job; sampled with `start`.
- `in_data`  in  N*Data_Width  : operand vector; lane i at bits [i*Data_Width +: Data_Width].
- `in_valid`  in  1  : `in_data` is valid.
- `in_ready`  out  1  : feeder accepts `in_data` this cycle.
- `waitrequest`  in  1  : global stall, shared with the MAC cells.
- `out_data`  out  N*Data_Width  : skewed lanes to the array edge; same packing as `in_data`.
- `out_valid`  out  N  : per-lane tag; bit i is high when lane i holds an accepted element, not a bubble or flush zero.
- `acc_clear`  out  1  : one-cycle pulse that resets the MAC accumulators.
- `busy`  out  1  : high in every state except IDLE.
- `done`  out  1  : one-cycle pulse marking end of job.

## Operation
- **States:** IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
- **IDLE**
  - `in_ready`=0 and the pipeline holds zero.
  - `start`=1 latches `len` into the remaining counter and moves to CLEAR.
- **CLEAR**
  - Lasts exactly 1 cycle with `acc_clear`=1, regardless of `waitrequest`.
  - Moves to FEED if K>0, or to DONE if K=0.
- **Advance:** the pipeline advances on any cycle in FEED, DRAIN or DONE with `waitrequest`=0. When `waitrequest`=1, all data, tags and counters hold.
- **FEED**
  - `in_ready` = !`waitrequest`.
  - On advance with `in_valid`=1: the vector enters with tags=1 and the remaining count decrements.
  - On advance with `in_valid`=0: a zero bubble enters with tags=0. This is harmless because the MAC adds 0.
  - Moves to DRAIN on the advance that accepts the K-th vector.
- **DRAIN**
  - `in_ready`=0.
  - Zeros with tags=0 enter on each advance.
  - Moves to DONE after N-1 advances. When N=1, DRAIN is skipped.
- **DONE**
  - `done`=1 and `busy`=1.
  - Waits for an advance (one zero shift), then returns to IDLE.
- **Ignored and priority cases**
  - `start` outside IDLE is ignored.
  - `rst` has priority over everything, including a simultaneous `start`.
  - `rst` mid-job returns to IDLE, zeros all lanes and tags, and emits no `done`.
- **Arithmetic:** data passes through unmodified; there is no sign extension or width change. The counter is LEN_W bits and never wraps, because it only decrements from K to 0.

## Timing
- **Reset values:** `out_data`=0, `out_valid`=0, `in_ready`=0, `acc_clear`=0, `busy`=0, `done`=0, state IDLE.
- **Lane latency:** an element accepted on advance a appears on lane i after advance a+i. Lane 0 has a latency of one register.
- **Job length without stalls:**
  - `start` at edge t0.
  - CLEAR runs during cycle t0+1.
  - The first accept occurs at edge t0+2.
  - `done` is high during the cycle after the last DRAIN advance.
  - Total from `start` to `done` is 2 + K + (N-1) cycles when `in_valid` is held high.
- **Stall alignment:** stalls add exactly one cycle each. Output values during a stall equal those on the preceding cycle, matching the MAC's hold behaviour.
- **Handshake:** `in_ready` is combinational from state and `waitrequest`. An input transfer occurs when both `in_valid` and `in_ready` are high at a posedge.

## Structure
- **Shared package `tpu_pkg`:**
  - state enum (IDLE, CLEAR, FEED, DRAIN, DONE);
  - lane slice helper constant/function;
  - default `Data_Width`/`N`.
- **Sub-module `skew_lane`:**
  - parameter DEPTH; Data_Width data + 1-bit tag shift register with advance enable and sync clear;
  - instantiated N times with DEPTH=i+1.

## Test plan
- **Basic skew:** N=4, K=3, lanes of vector v = {v*16+i}, `in_valid` held, no stalls → lane i shows 0x00,0x10,0x20 (plus i) starting i cycles after lane 0; `done` 2+3+3=8 cycles after `start`; `acc_clear` one cycle at t0+1.
- **Stall:** K=2, `waitrequest`=1 for 3 cycles mid-FEED → `out_data`/`out_valid` frozen for those cycles, no input accepted, `done` delayed by exactly 3.
- **Bubble:** K=2, `in_valid` low for 1 cycle between vectors → zero vector with tags 0 inserted on every lane; `done` delayed by 1; accept count is still 2.
- **Zero-length and ignored start:** `len`=0 → `acc_clear` then `done` on the next cycle, no tags set; `start` pulsed during FEED has no effect.
- **Reset mid-DRAIN:** `rst` asserted during DRAIN → next cycle all outputs 0, IDLE, no `done`; a new job afterwards runs correctly.
